lsu_mem_port: RTL and testbench

- Multi-cycle load/store unit. Takes one memory operation from the execute stage and drives a request/acknowledge data-memory port.
- Does byte-lane alignment for stores and loads: byte enables, write-data shifting, read-data extraction and sign/zero extension.
- Detects misaligned and illegal accesses, and faults on a memory acknowledge timeout.
- Returns a single-cycle response to writeback.

---
 rtl/lsu_pkg.sv | 38 +++
 rtl/lsu_align.sv | 52 +++++
 rtl/lsu_mem_port.sv | 175 +++++++++++++++++
 tb/tb_lsu_mem_port.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states and access sizes.
// Pure declarations; no logic or latency of its own.
// No flow control here; consumers own all handshaking.
package lsu_pkg;

  // Load funct3 encodings
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LD  = 3'b011;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] LWU = 3'b110;

  // Store funct3 encodings
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;
  localparam logic [2:0] SD  = 3'b011;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} lsu_state_t;

  // Access size as log2(bytes), taken straight from funct3[1:0]
  typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2, SZ_D = 2'd3} lsu_size_t;

  // Operation attributes held for the whole memory access
  typedef struct packed {
    logic      is_store;
    logic      is_unsigned;
    lsu_size_t size;
  } lsu_op_t;

  // Width of the byte-offset field inside a memory word
  function automatic int lsu_off_w(input int max_bytes);
    return $clog2(max_bytes);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment: byte enables, store-data lane shift, load-lane extract and extension.
// Purely combinational, zero latency.
// No flow control; outputs follow inputs directly.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int MAX_BYTES = XLEN / 8,
  parameter int OFFW      = lsu_off_w(MAX_BYTES)
) (
  input  lsu_size_t             size,
  input  logic [OFFW-1:0]       offset,
  input  logic                  is_unsigned,
  input  logic [XLEN-1:0]       wdata_in,
  input  logic [XLEN-1:0]       rdata_in,
  output logic [MAX_BYTES-1:0]  be,
  output logic [XLEN-1:0]       wdata_out,
  output logic [XLEN-1:0]       rdata_out
);

  int unsigned          nbytes;
  logic [MAX_BYTES-1:0] be_mask;
  logic [XLEN-1:0]      lane;
  logic                 sbit;

  assign wdata_out = wdata_in << {offset, 3'b000};
  assign lane      = rdata_in >> {offset, 3'b000};
  assign be        = be_mask << offset;

  // Contiguous low-aligned byte mask covering the access size
  always_comb begin
    nbytes = 32'd1 << size;
    for (int i = 0; i < MAX_BYTES; i++) begin
      be_mask[i] = (i < int'(nbytes));
    end
  end

  // Keep the accessed bytes and fill the rest with zeros or the sign bit
  always_comb begin
    case (size)
      SZ_B:    sbit = lane[7];
      SZ_H:    sbit = lane[15];
      SZ_W:    sbit = lane[31];
      default: sbit = lane[XLEN-1];
    endcase
    rdata_out = lane;
    for (int i = 0; i < XLEN; i++) begin
      if (i >= 8 * int'(nbytes)) rdata_out[i] = sbit & ~is_unsigned;
    end
  end

endmodule

// File: rtl/lsu_mem_port.sv
// Multi-cycle load/store unit driving a req/ack data-memory port with lane alignment and fault checks.
// Latency: decode faults respond 1 cycle after accept; memory ops respond 1 cycle after mem_ack (or timeout).
// Backpressure: req_ready only in IDLE; mem_req held until ack or timeout; no stall on the response.
module lsu_mem_port
  import lsu_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int MAX_BYTES = XLEN / 8,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 is_load,
  input  logic                 is_store,
  input  logic [2:0]           fn3,
  input  logic [XLEN-1:0]      addr,
  input  logic [XLEN-1:0]      store_data,
  output logic                 resp_valid,
  output logic [XLEN-1:0]      load_data,
  output logic                 misaligned,
  output logic                 illegal,
  output logic                 access_fault,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [XLEN-1:0]      mem_addr,
  output logic [MAX_BYTES-1:0] mem_be,
  output logic [XLEN-1:0]      mem_wdata,
  input  logic                 mem_ack,
  input  logic [XLEN-1:0]      mem_rdata
);

  localparam int OFFW = lsu_off_w(MAX_BYTES);
  localparam int CNTW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNTW-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNTW'(TIMEOUT - 1);

  lsu_state_t           state, state_nxt;
  lsu_op_t              op_q;
  logic [OFFW-1:0]      off_q;
  logic [XLEN-1:0]      addr_q, wdata_q, load_data_q;
  logic [CNTW-1:0]      cnt_q;
  logic                 mis_q, ill_q, fault_q;
  logic                 accept, dec_legal, dec_mis, timeout_hit;
  logic [OFFW-1:0]      req_off, mis_mask;
  lsu_size_t            req_size;
  logic [MAX_BYTES-1:0] al_be;
  logic [XLEN-1:0]      al_wdata, al_rdata;

  assign accept      = req_valid & (state == IDLE);
  assign req_off     = addr[OFFW-1:0];
  assign req_size    = lsu_size_t'(fn3[1:0]);
  // The cycle that would make the wait count reach TIMEOUT ends the access
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

  lsu_align #(.XLEN(XLEN), .MAX_BYTES(MAX_BYTES), .OFFW(OFFW)) u_align (
    .size        (op_q.size),
    .offset      (off_q),
    .is_unsigned (op_q.is_unsigned),
    .wdata_in    (wdata_q),
    .rdata_in    (mem_rdata),
    .be          (al_be),
    .wdata_out   (al_wdata),
    .rdata_out   (al_rdata)
  );

  // Decode legality and natural alignment of the offered operation
  always_comb begin
    dec_legal = 1'b0;
    if (is_load && !is_store) begin
      case (fn3)
        LB, LH, LW, LBU, LHU: dec_legal = 1'b1;
        LD, LWU:              dec_legal = (XLEN == 64);
        default:              dec_legal = 1'b0;
      endcase
    end else if (is_store && !is_load) begin
      case (fn3)
        SB, SH, SW: dec_legal = 1'b1;
        SD:         dec_legal = (XLEN == 64);
        default:    dec_legal = 1'b0;
      endcase
    end
    for (int i = 0; i < OFFW; i++) begin
      mis_mask[i] = (i < int'(req_size));
    end
    dec_mis = |(req_off & mis_mask);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: decode faults skip the memory, ack beats a coincident timeout
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (!dec_legal || dec_mis) ? RESP : ACCESS;
      ACCESS:  if (mem_ack || timeout_hit) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operation capture, wait counter, load result and response flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q        <= '0;
      off_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      mis_q       <= 1'b0;
      ill_q       <= 1'b0;
      fault_q     <= 1'b0;
      load_data_q <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op_q.is_store    <= is_store;
          op_q.is_unsigned <= fn3[2];
          op_q.size        <= req_size;
          off_q            <= req_off;
          addr_q           <= {addr[XLEN-1:OFFW], {OFFW{1'b0}}};
          wdata_q          <= store_data;
          cnt_q            <= '0;
          ill_q            <= ~dec_legal;
          mis_q            <= dec_legal & dec_mis;
          fault_q          <= 1'b0;
          load_data_q      <= '0;
        end
        ACCESS: begin
          if (mem_ack) begin
            if (!op_q.is_store) load_data_q <= al_rdata;
          end else if (timeout_hit) begin
            fault_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNTW'(1);
          end
        end
        RESP: begin
          mis_q       <= 1'b0;
          ill_q       <= 1'b0;
          fault_q     <= 1'b0;
          load_data_q <= '0;
        end
        default: ;
      endcase
    end
  end

  // Outputs: memory port is live only during ACCESS, response only in RESP
  always_comb begin
    req_ready  = (state == IDLE);
    resp_valid = (state == RESP);
    mem_req    = (state == ACCESS);
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_be     = '0;
    mem_wdata  = '0;
    if (state == ACCESS) begin
      mem_we    = op_q.is_store;
      mem_addr  = addr_q;
      mem_be    = al_be;
      mem_wdata = al_wdata;
    end
  end

  assign load_data    = load_data_q;
  assign misaligned   = mis_q;
  assign illegal      = ill_q;
  assign access_fault = fault_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
module tb_lsu_mem_port;

  logic clk, rst_n;

  // 32-bit instance signals
  logic        a_req_valid, a_req_ready, a_is_load, a_is_store;
  logic [2:0]  a_fn3;
  logic [31:0] a_addr, a_store_data, a_load_data, a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic        a_resp_valid, a_misaligned, a_illegal, a_access_fault;
  logic        a_mem_req, a_mem_we, a_mem_ack;
  logic [3:0]  a_mem_be;

  // 64-bit instance signals
  logic        b_req_valid, b_req_ready, b_is_load, b_is_store;
  logic [2:0]  b_fn3;
  logic [63:0] b_addr, b_store_data, b_load_data, b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic        b_resp_valid, b_misaligned, b_illegal, b_access_fault;
  logic        b_mem_req, b_mem_we, b_mem_ack;
  logic [7:0]  b_mem_be;

  int n_tests = 0;
  int n_fail  = 0;

  lsu_mem_port #(.XLEN(32), .TIMEOUT(4)) u_a (
    .clk(clk), .rst_n(rst_n), .req_valid(a_req_valid), .req_ready(a_req_ready),
    .is_load(a_is_load), .is_store(a_is_store), .fn3(a_fn3), .addr(a_addr),
    .store_data(a_store_data), .resp_valid(a_resp_valid), .load_data(a_load_data),
    .misaligned(a_misaligned), .illegal(a_illegal), .access_fault(a_access_fault),
    .mem_req(a_mem_req), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_be(a_mem_be),
    .mem_wdata(a_mem_wdata), .mem_ack(a_mem_ack), .mem_rdata(a_mem_rdata)
  );

  lsu_mem_port #(.XLEN(64), .TIMEOUT(4)) u_b (
    .clk(clk), .rst_n(rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .is_load(b_is_load), .is_store(b_is_store), .fn3(b_fn3), .addr(b_addr),
    .store_data(b_store_data), .resp_valid(b_resp_valid), .load_data(b_load_data),
    .misaligned(b_misaligned), .illegal(b_illegal), .access_fault(b_access_fault),
    .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_be(b_mem_be),
    .mem_wdata(b_mem_wdata), .mem_ack(b_mem_ack), .mem_rdata(b_mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // phase: 0 waiting for an op, 1 memory busy, 2 answering
  typedef struct {
    int          phase;
    int          waitc;
    int          off;
    logic        ld_op;
    logic [2:0]  f;
    logic [63:0] e_addr, e_be, e_wdata, e_ld;
    logic        e_we, e_mis, e_ill, e_af;
  } mdl_t;

  mdl_t ma, mb;

  function automatic mdl_t m_zero();
    mdl_t m;
    m.phase = 0; m.waitc = 0; m.off = 0; m.ld_op = 1'b0; m.f = 3'b0;
    m.e_addr = '0; m.e_be = '0; m.e_wdata = '0; m.e_ld = '0;
    m.e_we = 1'b0; m.e_mis = 1'b0; m.e_ill = 1'b0; m.e_af = 1'b0;
    return m;
  endfunction

  function automatic logic m_illegal(input int xlen, input logic ld, input logic st, input logic [2:0] f);
    if (ld == st) return 1'b1;
    if (ld) return !(f == 3'd0 || f == 3'd1 || f == 3'd2 || f == 3'd4 || f == 3'd5 ||
                     (xlen == 64 && (f == 3'd3 || f == 3'd6)));
    return !(f == 3'd0 || f == 3'd1 || f == 3'd2 || (xlen == 64 && f == 3'd3));
  endfunction

  function automatic logic [63:0] m_be(input int off, input int sz);
    logic [63:0] r = '0;
    for (int i = 0; i < sz; i++) r[off + i] = 1'b1;
    return r;
  endfunction

  function automatic logic [63:0] m_wdata(input logic [63:0] sd, input int off, input int sz);
    logic [63:0] r = '0;
    for (int i = 0; i < sz; i++) r[8*(off+i) +: 8] = sd[8*i +: 8];
    return r;
  endfunction

  function automatic logic [63:0] m_load(input logic [63:0] rd, input int off, input int sz,
                                         input logic uns, input int xlen);
    logic [63:0] v = '0;
    for (int i = 0; i < sz; i++) v[8*i +: 8] = rd[8*(off+i) +: 8];
    if (!uns && v[8*sz-1]) for (int b = 8*sz; b < xlen; b++) v[b] = 1'b1;
    return v;
  endfunction

  function automatic mdl_t step(input mdl_t m0, input int xlen, input int tmo,
                                input logic rv, input logic ld, input logic st,
                                input logic [2:0] f, input logic [63:0] ad,
                                input logic [63:0] sd, input logic ack, input logic [63:0] rd);
    mdl_t m;
    int   sz;
    m = m0;
    case (m.phase)
      0: if (rv) begin
        m.off   = int'(ad[2:0]) % (xlen / 8);
        sz      = 1 << f[1:0];
        m.f     = f;
        m.ld_op = ld;
        m.e_ill = m_illegal(xlen, ld, st, f);
        m.e_mis = !m.e_ill && ((m.off % sz) != 0);
        m.e_af  = 1'b0;
        m.e_ld  = '0;
        if (m.e_ill || m.e_mis) m.phase = 2;
        else begin
          m.phase   = 1;
          m.waitc   = 0;
          m.e_addr  = ad - 64'(m.off);
          m.e_be    = m_be(m.off, sz);
          m.e_wdata = m_wdata(sd, m.off, sz);
          m.e_we    = st;
        end
      end
      1: if (ack) begin
        m.phase = 2;
        m.e_ld  = m.ld_op ? m_load(rd, m.off, 1 << m.f[1:0], m.f[2], xlen) : 64'd0;
      end else begin
        m.waitc = m.waitc + 1;
        if (tmo != 0 && m.waitc == tmo) begin
          m.phase = 2;
          m.e_af  = 1'b1;
        end
      end
      default: begin
        m.phase = 0; m.e_mis = 1'b0; m.e_ill = 1'b0; m.e_af = 1'b0; m.e_ld = '0;
      end
    endcase
    return m;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma <= m_zero();
      mb <= m_zero();
    end else begin
      ma <= step(ma, 32, 4, a_req_valid, a_is_load, a_is_store, a_fn3, {32'd0, a_addr},
                 {32'd0, a_store_data}, a_mem_ack, {32'd0, a_mem_rdata});
      mb <= step(mb, 64, 4, b_req_valid, b_is_load, b_is_store, b_fn3, b_addr,
                 b_store_data, b_mem_ack, b_mem_rdata);
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cmp(input string t, input mdl_t m, input logic rr, input logic rv,
                     input logic mis, input logic ill, input logic af, input logic mreq,
                     input logic mwe, input logic [63:0] ld, input logic [63:0] maddr,
                     input logic [63:0] be, input logic [63:0] wd);
    check({t, ".req_ready"},  rr,   m.phase == 0);
    check({t, ".resp_valid"}, rv,   m.phase == 2);
    check({t, ".mem_req"},    mreq, m.phase == 1);
    if (m.phase == 1) begin
      check({t, ".mem_we"},    mwe,   m.e_we);
      check({t, ".mem_addr"},  maddr, m.e_addr);
      check({t, ".mem_be"},    be,    m.e_be);
      check({t, ".mem_wdata"}, wd,    m.e_wdata);
    end else begin
      check({t, ".misaligned"},   mis, m.phase == 2 && m.e_mis);
      check({t, ".illegal"},      ill, m.phase == 2 && m.e_ill);
      check({t, ".access_fault"}, af,  m.phase == 2 && m.e_af);
      check({t, ".load_data"},    ld,  (m.phase == 2) ? m.e_ld : 64'd0);
    end
  endtask

  always @(negedge clk) begin
    cmp("a", ma, a_req_ready, a_resp_valid, a_misaligned, a_illegal, a_access_fault,
        a_mem_req, a_mem_we, {32'd0, a_load_data}, {32'd0, a_mem_addr},
        {60'd0, a_mem_be}, {32'd0, a_mem_wdata});
    cmp("b", mb, b_req_ready, b_resp_valid, b_misaligned, b_illegal, b_access_fault,
        b_mem_req, b_mem_we, b_load_data, b_mem_addr, {56'd0, b_mem_be}, b_mem_wdata);
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic offer_a(input logic ld, input logic st, input logic [2:0] f,
                         input logic [31:0] ad, input logic [31:0] sd);
    a_req_valid = 1'b1; a_is_load = ld; a_is_store = st; a_fn3 = f;
    a_addr = ad; a_store_data = sd;
    tick();
    a_req_valid = 1'b0;
  endtask

  task automatic offer_b(input logic ld, input logic st, input logic [2:0] f,
                         input logic [63:0] ad, input logic [63:0] sd);
    b_req_valid = 1'b1; b_is_load = ld; b_is_store = st; b_fn3 = f;
    b_addr = ad; b_store_data = sd;
    tick();
    b_req_valid = 1'b0;
  endtask

  initial begin
    int req_cycles;
    int resp_seen;
    logic af_seen;

    rst_n = 1'b0;
    a_req_valid = 0; a_is_load = 0; a_is_store = 0; a_fn3 = 0; a_addr = 0;
    a_store_data = 0; a_mem_ack = 0; a_mem_rdata = 0;
    b_req_valid = 0; b_is_load = 0; b_is_store = 0; b_fn3 = 0; b_addr = 0;
    b_store_data = 0; b_mem_ack = 0; b_mem_rdata = 0;
    repeat (3) tick();
    check("reset req_ready", a_req_ready, 1'b1);
    check("reset mem_req",   a_mem_req,   1'b0);
    check("reset mem_be",    a_mem_be,    4'b0000);
    check("reset load_data", b_load_data, 64'd0);
    rst_n = 1'b1;
    tick();

    // LB at 0x103, ack in the second access cycle
    offer_a(1, 0, 3'b000, 32'h103, 32'h0);
    check("lb mem_req",  a_mem_req,  1'b1);
    check("lb mem_addr", a_mem_addr, 32'h100);
    check("lb mem_be",   a_mem_be,   4'b1000);
    check("lb mem_we",   a_mem_we,   1'b0);
    tick();
    a_mem_ack = 1'b1; a_mem_rdata = 32'h80FF_FF12;
    tick();
    a_mem_ack = 1'b0;
    check("lb resp_valid", a_resp_valid, 1'b1);
    check("lb load_data",  a_load_data,  32'hFFFF_FF80);
    check("lb model",      ma.e_ld,      64'h0000_0000_FFFF_FF80);
    tick();

    // SH at 0x102
    offer_a(0, 1, 3'b001, 32'h102, 32'h0000_ABCD);
    check("sh mem_we",    a_mem_we,    1'b1);
    check("sh mem_be",    a_mem_be,    4'b1100);
    check("sh mem_wdata", a_mem_wdata, 32'hABCD_0000);
    check("sh model",     ma.e_wdata,  64'h0000_0000_ABCD_0000);
    a_mem_ack = 1'b1; a_mem_rdata = 32'hDEAD_BEEF;
    tick();
    a_mem_ack = 1'b0;
    check("sh resp_valid", a_resp_valid, 1'b1);
    check("sh load_data",  a_load_data,  32'h0);
    tick();

    // Decode faults: misaligned LW, LD on XLEN=32 (illegal beats misaligned), both/neither op bits
    offer_a(1, 0, 3'b010, 32'h101, 32'h0);
    check("lw-mis mem_req",    a_mem_req,    1'b0);
    check("lw-mis resp_valid", a_resp_valid, 1'b1);
    check("lw-mis misaligned", a_misaligned, 1'b1);
    check("lw-mis illegal",    a_illegal,    1'b0);
    tick();
    offer_a(1, 0, 3'b011, 32'h101, 32'h0);
    check("ld32 illegal",    a_illegal,    1'b1);
    check("ld32 misaligned", a_misaligned, 1'b0);
    tick();
    offer_a(1, 1, 3'b000, 32'h100, 32'h0);
    check("both illegal", a_illegal, 1'b1);
    tick();
    offer_a(0, 0, 3'b000, 32'h100, 32'h0);
    check("neither illegal", a_illegal, 1'b1);
    tick();

    // Timeout: no ack, mem_req must be high exactly 4 cycles
    offer_a(1, 0, 3'b010, 32'h200, 32'h0);
    req_cycles = 0; af_seen = 1'b0; resp_seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (a_mem_req) req_cycles++;
      if (a_resp_valid) begin resp_seen++; af_seen = a_access_fault; end
      tick();
    end
    check("tmo req cycles", req_cycles, 4);
    check("tmo responses",  resp_seen,  1);
    check("tmo fault",      af_seen,    1'b1);

    // Ack in the 4th access cycle wins over the timeout
    offer_a(1, 0, 3'b010, 32'h200, 32'h0);
    tick(); tick(); tick();
    a_mem_ack = 1'b1; a_mem_rdata = 32'h1234_5678;
    tick();
    a_mem_ack = 1'b0;
    check("ack4 resp_valid", a_resp_valid,   1'b1);
    check("ack4 fault",      a_access_fault, 1'b0);
    check("ack4 load_data",  a_load_data,    32'h1234_5678);
    tick();

    // XLEN=64: LWU / LW at 0x204, LD at 0x204 misaligned
    offer_b(1, 0, 3'b110, 64'h204, 64'h0);
    check("lwu mem_addr", b_mem_addr, 64'h200);
    check("lwu mem_be",   b_mem_be,   8'hF0);
    b_mem_ack = 1'b1; b_mem_rdata = 64'h8765_4321_0000_0000;
    tick();
    b_mem_ack = 1'b0;
    check("lwu load_data", b_load_data, 64'h0000_0000_8765_4321);
    tick();
    offer_b(1, 0, 3'b010, 64'h204, 64'h0);
    b_mem_ack = 1'b1; b_mem_rdata = 64'h8765_4321_0000_0000;
    tick();
    b_mem_ack = 1'b0;
    check("lw64 load_data", b_load_data, 64'hFFFF_FFFF_8765_4321);
    check("lw64 model",     mb.e_ld,     64'hFFFF_FFFF_8765_4321);
    tick();
    offer_b(1, 0, 3'b011, 64'h204, 64'h0);
    check("ld64 misaligned", b_misaligned, 1'b1);
    check("ld64 mem_req",    b_mem_req,    1'b0);
    tick();
    offer_b(0, 1, 3'b011, 64'h208, 64'h0102_0304_0506_0708);
    check("sd mem_be",    b_mem_be,    8'hFF);
    check("sd mem_wdata", b_mem_wdata, 64'h0102_0304_0506_0708);
    b_mem_ack = 1'b1;
    tick();
    b_mem_ack = 1'b0;
    tick();

    // Reset in the middle of an access
    offer_a(1, 0, 3'b010, 32'h300, 32'h0);
    tick();
    rst_n = 1'b0;
    #1;
    check("rst mem_req",    a_mem_req,    1'b0);
    check("rst resp_valid", a_resp_valid, 1'b0);
    tick();
    rst_n = 1'b1;
    check("rst req_ready", a_req_ready, 1'b1);
    resp_seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (a_resp_valid) resp_seen++;
      tick();
    end
    check("rst stray resp", resp_seen, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
